// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx
//   Queues ASCII bytes from the character generator in a small circular FIFO
//   and sends each one on a single pin as an 8N1 UART frame, LSB first.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (2..65535)
//   FIFO_DEPTH   : FIFO entries, power of two (2..16)
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data_in    : byte to queue, held stable while data_valid is high
//   data_valid : producer offers data_in
//   data_ready : FIFO has room; a byte is taken when data_valid && data_ready
//   tx         : serial line, idles high, registered
//   busy       : a frame is on the line (START, DATA or STOP)
//   fifo_count : bytes waiting in the FIFO, not counting the one being shifted
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [15:0]    baud_reg, baud_next;
  logic [2:0]     bit_reg, bit_next;
  logic [7:0]     shreg_reg, shreg_next;
  logic           tx_reg, tx_next;
  logic           push, pop, baud_tc;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // byte even on the edge that pops it.
  assign data_ready = (count_reg != DEPTH_C);
  assign push       = data_valid && data_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  assign baud_tc    = (baud_reg == BAUD_LAST);

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE);
  assign fifo_count = count_reg;

  // Storage has no reset so it can map onto distributed RAM; stale
  // contents are never read because the count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers are exactly PW bits wide, so the power-of-two depth makes
  // them wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    tx_next    = 1'b1;

    case (state_reg)
      IDLE: begin
        if (pop) begin
          shreg_next = mem[rd_ptr_reg];
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_next  = '0;
          shreg_next = {1'b0, shreg_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // The line level is computed for the state being entered and then
    // registered, so tx changes exactly on the state edge without glitches.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx
//   Directed bench for ascii_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
//   A line monitor decodes every frame on tx; scenarios compare the decoded
//   bytes, frame spacing and FIFO status against hand-computed values.
module tb_ascii_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [7:0] data_in    = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  ascii_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- line monitor ----------------
  logic [7:0] rx_q[$];
  int         rx_t_q[$];
  bit         rx_ok_q[$];
  bit         mon_prev = 1'b1;

  initial begin
    logic [7:0] b;
    logic       sb, stp;
    int         t0;
    forever begin
      @(negedge clk);
      if (mon_prev && (tx === 1'b0)) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stp = tx;
        rx_q.push_back(b);
        rx_t_q.push_back(t0);
        rx_ok_q.push_back((sb === 1'b0) && (stp === 1'b1));
        $display("rx byte 0x%02h start cycle %0d framing %0d", b, t0, (sb === 1'b0) && (stp === 1'b1));
        mon_prev = 1'b1;
      end else begin
        mon_prev = (tx !== 1'b0);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("send_wait", 32'(t < 500), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || fifo_count != 3'd0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 32'(t < 3000), 32'd1);
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] exp, output int start);
    logic [7:0] b;
    bit         ok;
    start = 0;
    wait_rx(1);
    if (rx_q.size() == 0) begin
      check({tag, "_missing"}, 32'(rx_q.size()), 32'd1);
    end else begin
      b     = rx_q.pop_front();
      ok    = rx_ok_q.pop_front();
      start = rx_t_q.pop_front();
      check(tag, 32'(b), 32'(exp));
      check({tag, "_framing"}, 32'(ok), 32'd1);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [9:0] frame;
    int         busy_cnt, bad, t_prev, t_cur;
    logic [7:0] lo;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(data_ready), 32'd1);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_50_cycles", 32'(bad), 32'd0);

    // Single byte 'A'
    data_in    = 8'h41;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("single_count_after_push", 32'(fifo_count), 32'd1);
    check("single_tx_still_high", 32'(tx), 32'd1);
    @(negedge clk);
    check("single_tx_fall", 32'(tx), 32'd0);
    check("single_busy_rise", 32'(busy), 32'd1);
    check("single_count_after_pop", 32'(fifo_count), 32'd0);
    frame    = '0;
    frame[0] = tx;
    busy_cnt = 1;
    for (int k = 1; k < 46; k++) begin
      @(negedge clk);
      if (k < 40 && (k % 4) == 0) frame[k / 4] = tx;
      if (busy) busy_cnt++;
    end
    check("single_bit_samples", 32'(frame), 32'(10'b1010000010));
    check("single_busy_cycles", 32'(busy_cnt), 32'd40);
    expect_rx("single_rx", 8'h41, t_cur);

    // Burst with backpressure
    wait_idle();
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    check("burst_full_count", 32'(fifo_count), 32'd4);
    check("burst_ready_low", 32'(data_ready), 32'd0);
    send(8'h35);
    data_valid = 1'b0;
    check("burst_held_accept_count", 32'(fifo_count), 32'd4);
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      expect_rx($sformatf("burst_rx%0d", i), 8'h30 + 8'(i), t_cur);
      if (i > 0) check($sformatf("burst_spacing%0d", i), 32'(t_cur - t_prev), 32'd41);
      t_prev = t_cur;
    end
    check("burst_no_extra", 32'(rx_q.size()), 32'd0);

    // Simultaneous push and pop
    wait_idle();
    send(8'h61);
    send(8'h62);
    send(8'h63);
    data_valid = 1'b0;
    check("simul_pre_count", 32'(fifo_count), 32'd2);
    bad = 0;
    while (busy && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    check("simul_idle_seen", 32'(busy), 32'd0);
    data_in    = 8'h64;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("simul_count_kept", 32'(fifo_count), 32'd2);
    check("simul_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) expect_rx($sformatf("simul_rx%0d", i), 8'h61 + 8'(i), t_cur);

    // Pointer wrap: 10 bytes in groups of 3
    wait_idle();
    for (int g = 0; g < 10; g += 3) begin
      for (int j = g; j < g + 3 && j < 10; j++) send(8'h41 + 8'(j));
      data_valid = 1'b0;
      for (int j = g; j < g + 3 && j < 10; j++) expect_rx($sformatf("wrap_rx%0d", j), 8'h41 + 8'(j), t_cur);
      wait_idle();
    end

    // Reset during DATA bit 3 with two bytes queued
    send(8'h58);
    send(8'h59);
    send(8'h5A);
    data_valid = 1'b0;
    check("midrst_pre_count", 32'(fifo_count), 32'd2);
    repeat (17) @(negedge clk);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
    rx_t_q.delete();
    rx_ok_q.delete();
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midrst_quiet", 32'(bad), 32'd0);
    check("midrst_no_frame", 32'(rx_q.size()), 32'd0);
    check("midrst_count_after", 32'(fifo_count), 32'd0);
    lo = 8'h5B;
    send(lo);
    data_valid = 1'b0;
    expect_rx("midrst_new_rx", lo, t_cur);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

endmodule
